pipeline_hazard_ctrl: RTL

Central pipeline sequencer for the 19-bit, 5-stage core. It drives the write-enables of the PC and the IF/ID register (IF_IDwrite), and the bubble/flush controls of IF/ID, ID/EX and EX/MEM. It resolves load-use hazards, taken-branch flushes, multi-cycle EX operations and data-memory wait states. Its state machine and stall counters are the only place where pipeline advance is decided.

---
 rtl/pipeline_hazard_ctrl_if.sv | 39 +++
 rtl/pipeline_hazard_ctrl.sv | 121 ++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline hazard controller bus: hazard-relevant fields from ID/EX/MEM
// flowing in, and the per-stage write/flush controls flowing back out.
interface pipeline_hazard_ctrl_if #(
  parameter int REG_AW = 3,
  parameter int CNT_W  = 16
);
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic              ex_mem_read;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_branch_taken;
  logic              ex_mc_start;
  logic              mem_busy;
  logic              pc_write;
  logic              IF_IDwrite;
  logic              if_id_flush;
  logic              id_ex_write;
  logic              id_ex_bubble;
  logic              ex_mem_bubble;
  logic [CNT_W-1:0]  stall_cycles;

  // Core datapath side: supplies pipeline status, consumes controls.
  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    output ex_mem_read, ex_rd, ex_branch_taken, ex_mc_start, mem_busy,
    input  pc_write, IF_IDwrite, if_id_flush, id_ex_write,
    input  id_ex_bubble, ex_mem_bubble, stall_cycles
  );

  // Controller side.
  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    input  ex_mem_read, ex_rd, ex_branch_taken, ex_mc_start, mem_busy,
    output pc_write, IF_IDwrite, if_id_flush, id_ex_write,
    output id_ex_bubble, ex_mem_bubble, stall_cycles
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Central pipeline sequencer: decides every cycle whether the 5-stage pipe
// advances, stalls, freezes or flushes. Controls are combinational so they
// act in the cycle the hazard is seen; only state and the stall counter
// are registered.
module pipeline_hazard_ctrl #(
  parameter int REG_AW = 3,
  parameter int MC_LAT = 4,
  parameter int CNT_W  = 16
) (
  input logic                  clk,
  input logic                  rst,
  pipeline_hazard_ctrl_if.slave bus
);
  localparam int MC_W = $clog2(MC_LAT);
  localparam logic [MC_W-1:0]   MC_LOAD = MC_W'(MC_LAT - 2);
  localparam logic [REG_AW-1:0] R_ZERO  = '0;

  typedef enum logic {RUN, MC_WAIT} state_t;

  state_t            state_reg, state_next;
  logic [MC_W-1:0]   mc_cnt_reg, mc_cnt_next;
  logic [CNT_W-1:0]  stall_reg;
  logic              load_use;
  logic              pc_write, if_id_write, id_ex_write;
  logic              if_id_flush, id_ex_bubble, ex_mem_bubble;

  // Load-use hazard: the loaded register is needed by ID next cycle.
  // r0 is hard-wired zero, so a load "into" r0 never creates a dependency.
  always_comb begin
    load_use = bus.ex_mem_read && (bus.ex_rd != R_ZERO) &&
               ((bus.id_use_rs1 && (bus.id_rs1 == bus.ex_rd)) ||
                (bus.id_use_rs2 && (bus.id_rs2 == bus.ex_rd)));
  end

  // State register, multi-cycle down-counter and saturating stall counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= RUN;
      mc_cnt_reg <= '0;
      stall_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      mc_cnt_reg <= mc_cnt_next;
      if (!pc_write && (stall_reg != {CNT_W{1'b1}}))
        stall_reg <= stall_reg + CNT_W'(1);
    end
  end

  // Next state: a frozen pipe cannot launch a multi-cycle op nor retire one,
  // but the op's own latency keeps elapsing underneath the freeze.
  always_comb begin
    state_next  = state_reg;
    mc_cnt_next = mc_cnt_reg;
    case (state_reg)
      RUN: begin
        if (!bus.mem_busy && bus.ex_mc_start) begin
          state_next  = MC_WAIT;
          mc_cnt_next = MC_LOAD;
        end
      end
      MC_WAIT: begin
        if (mc_cnt_reg != '0)
          mc_cnt_next = mc_cnt_reg - MC_W'(1);
        else if (!bus.mem_busy)
          state_next = RUN;
      end
      default: begin
        state_next  = RUN;
        mc_cnt_next = '0;
      end
    endcase
  end

  // Pipeline controls in priority order: reset, freeze, multi-cycle,
  // branch flush, load-use. A taken branch squashes ID anyway, so it wins
  // over a load-use stall on the same instruction.
  always_comb begin
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    id_ex_write   = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_bubble  = 1'b0;
    ex_mem_bubble = 1'b0;
    if (rst) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      id_ex_write   = 1'b0;
      if_id_flush   = 1'b1;
      id_ex_bubble  = 1'b1;
      ex_mem_bubble = 1'b1;
    end else if (bus.mem_busy) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_write = 1'b0;
    end else if ((state_reg == MC_WAIT && mc_cnt_reg != '0) ||
                 (state_reg == RUN && bus.ex_mc_start)) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      id_ex_write   = 1'b0;
      ex_mem_bubble = 1'b1;
    end else if (state_reg == RUN && bus.ex_branch_taken) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (state_reg == RUN && load_use) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
    end
  end

  // Drive the bus from the local control terms.
  always_comb begin
    bus.pc_write      = pc_write;
    bus.IF_IDwrite    = if_id_write;
    bus.id_ex_write   = id_ex_write;
    bus.if_id_flush   = if_id_flush;
    bus.id_ex_bubble  = id_ex_bubble;
    bus.ex_mem_bubble = ex_mem_bubble;
    bus.stall_cycles  = stall_reg;
  end
endmodule
